// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the banked shared-memory initiator path.
package gpu_mem_pkg;

   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned BANK_W    = 4;
   localparam int unsigned OFF_W     = 8;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned NUM_CORES = 16;
   localparam int unsigned NUM_BANKS = 16;
   localparam int unsigned REQ_W     = 1 + ADDR_W + DATA_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } port_state_e;

   // One queued core request: bank is addr[ADDR_W-1 -: BANK_W], offset the low OFF_W bits
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Pick the byte lane belonging to one bank out of the flattened per-bank bus
   function automatic logic [DATA_W-1:0] bank_lane(
      input logic [NUM_BANKS*DATA_W-1:0] lanes,
      input logic [BANK_W-1:0]           bank
   );
      return lanes[32'(bank) * DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/core_mem_port_req_fifo.sv
// Request FIFO: power-of-two depth, pointers carry one extra wrap bit for full/empty.
module req_fifo
   import gpu_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     push,
   input  mem_req_t push_data,
   input  logic     pop,
   output mem_req_t pop_data,
   output logic     full,
   output logic     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   mem_req_t         mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   // Pointer update; pushes into a full FIFO and pops from an empty one are dropped
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage write; contents need no reset since empty masks them
   always_ff @(posedge clock) begin
      if (push && !full)
         mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/core_mem_port.sv
// Core-side initiator: queues requests, drives one bank transaction at a time, returns responses.
module core_mem_port
   import gpu_mem_pkg::*;
#(
   parameter int unsigned CORE_ID    = 0,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_we,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [DATA_W-1:0]           req_wdata,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [DATA_W-1:0]           resp_rdata,
   output logic                        resp_err,
   output logic                        mem_val,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_data,
   input  logic [NUM_BANKS-1:0]        bank_finish,
   input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   if ((CORE_ID >= NUM_CORES) || (FIFO_DEPTH < 2) ||
       ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_params
      $error("core_mem_port: parameter out of range");
   end

   port_state_e       state;
   port_state_e       state_nxt;
   mem_req_t          cur_q;
   mem_req_t          fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [7:0]        wait_cnt;
   logic [BANK_W-1:0] bank;
   logic              finish_hit;
   logic              timed_out;

   assign bank       = cur_q.addr[ADDR_W-1 -: BANK_W];
   assign finish_hit = bank_finish[bank];
   assign timed_out  = (wait_cnt == TIMEOUT_C);
   assign req_ready  = !fifo_full;

   req_fifo #(.DEPTH(FIFO_DEPTH)) u_req_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (req_valid),
      .push_data ({req_we, req_addr, req_wdata}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: finish on the decoded bank beats a coincident timeout
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (!fifo_empty) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT: begin
            if (finish_hit)     state_nxt = CAPTURE;
            else if (timed_out) state_nxt = RESP;
         end
         CAPTURE: state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state: bank request lines only while ISSUE/WAIT
   always_comb begin
      mem_val    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_data   = '0;
      resp_valid = 1'b0;
      fifo_pop   = 1'b0;
      case (state)
         IDLE: fifo_pop = !fifo_empty;
         ISSUE, WAIT: begin
            mem_val   = 1'b1;
            mem_read  = !cur_q.we;
            mem_write = cur_q.we;
            mem_addr  = cur_q.addr;
            mem_data  = cur_q.wdata;
         end
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Working registers, saturating wait counter and response payload
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_q      <= '0;
         wait_cnt   <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cur_q    <= fifo_head;
                  resp_err <= 1'b0;
               end
            end
            ISSUE: wait_cnt <= '0;
            WAIT: begin
               if (!finish_hit) begin
                  if (timed_out) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (wait_cnt != 8'hFF) begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
            end
            CAPTURE: resp_rdata <= cur_q.we ? '0 : bank_lane(bank_rdata, bank);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/core_mem_port.md
# core_mem_port

Core-side initiator for the banked shared memory. Each core owns one `core_mem_port`. It buffers the core's load/store requests and decodes the target bank from the address. It then drives the request lines that every `bank_arbiter` samples, waits for that bank's arbiter to raise this core's finish bit, captures the read byte, and returns a response to the core.

## Interface
Parameters:
- `CORE_ID`, default 0: index of this core (0..15); selects nothing internally, reported for bench checks only.
- `FIFO_DEPTH`, default 2: request FIFO entries; power of two, at least 2.
- `TIMEOUT`, default 255: maximum WAIT cycles before an error response; range 1..255.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: core request valid.
- `req_ready`, out, 1: FIFO not full.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, 12: [11:8] bank, [7:0] word offset.
- `req_wdata`, in, 8: store data.
- `resp_valid`, out, 1: response valid; held until accepted.
- `resp_ready`, in, 1: core accepts response.
- `resp_rdata`, out, 8: load data; 0 for stores and errors.
- `resp_err`, out, 1: response is a timeout.
- `mem_val`, out, 1: this core's `core_val` bit.
- `mem_read`, out, 1: this core's `read` bit.
- `mem_write`, out, 1: this core's `write` bit.
- `mem_addr`, out, 12: this core's 12-bit `addr_in` field.
- `mem_data`, out, 8: this core's `data_in` byte.
- `bank_finish`, in, 16: bit b = finish[CORE_ID] of bank b's arbiter.
- `bank_rdata`, in, 128: lane b ([8b+7:8b]) = this core's `data_out` byte from bank b's arbiter.

## Operation
- Request FIFO: a write happens on `req_valid && req_ready`. `req_ready = !full`, a combinational function of FIFO state only. A request offered while the FIFO is full is ignored.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the working registers (`we`, `addr`, `wdata`, `bank = addr[11:8]`) and go to ISSUE.
  - ISSUE: one cycle. `mem_*` driven; the wait counter is cleared. Go to WAIT.
  - WAIT: `mem_*` held. If `bank_finish[bank]` is set, go to CAPTURE. Otherwise, if the counter equals `TIMEOUT`, go to RESP with `err = 1`. Otherwise increment the counter.
  - CAPTURE: `mem_*` deasserted. For a load, latch `bank_rdata[8*bank +: 8]` into `resp_rdata`; for a store, latch 0. Go to RESP.
  - RESP: `resp_valid = 1`. On `resp_ready`, go to IDLE.
- `mem_val = mem_read | mem_write`. `mem_read = !we`, `mem_write = we`, asserted only in ISSUE and WAIT. `mem_addr` and `mem_data` are zero outside ISSUE and WAIT.
- The wait counter is 8-bit and saturates; it never wraps.
- Only the finish bit of the decoded bank counts. Finish pulses from other banks in WAIT are ignored, and so is any finish pulse outside WAIT.
- A finish and the timeout in the same cycle: finish wins, and the response is normal.
- One outstanding memory transaction at a time; the next FIFO entry is not popped before RESP completes.

## Timing
- Reset values: `req_ready = 1`, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`, all `mem_*` = 0. FIFO empty, state IDLE, counter 0.
- Reset mid-transaction: all in-flight and queued requests are dropped. `mem_*` is 0 in the cycle after the reset edge. No response is issued.
- Request accepted at edge T into an empty, idle port: the pop happens at edge T+1, and `mem_*` is high in the cycle after edge T+1 (the ISSUE cycle).
- Finish sampled high in WAIT at edge F: `mem_*` is low after F, data is latched at F+1, and `resp_valid` is high after F+1.
- Best-case turnaround from acceptance to `resp_valid`: 4 cycles.
- Timeout: with no finish, RESP is entered TIMEOUT+1 cycles after ISSUE.
- `resp_valid` and `resp_rdata` are stable while `resp_ready` is low. Back-to-back requests lose one IDLE cycle between transactions.

## Structure
- Shared package `gpu_mem_pkg` holds:
  - `ADDR_W = 12`, `BANK_W = 4`, `OFF_W = 8`, `DATA_W = 8`, `NUM_CORES = 16`, `NUM_BANKS = 16`;
  - the FSM state enum {IDLE, ISSUE, WAIT, CAPTURE, RESP};
  - the function for lane extraction by bank index.
- One sub-module, `req_fifo`: a synchronous FIFO, FIFO_DEPTH × 21 bits (we, addr, wdata), with `full`/`empty` flags and wrapping pointers plus an extra bit.

## Test plan
- Load, CORE_ID=3: request addr 0x5A7. Expect `mem_read=1`, `mem_addr=0x5A7` in ISSUE. Pulse `bank_finish[5]` with `bank_rdata[47:40]=0x3C` → `resp_rdata=0x3C`, `resp_err=0`.
- Store addr 0x2F0, data 0x81 → `mem_write=1`, `mem_data=0x81`. Finish on bank 2 → `resp_rdata=0`, `resp_err=0`.
- Load to bank 7 while pulsing only `bank_finish[6]`, TIMEOUT=10 → no completion; `resp_err=1` exactly 11 cycles after ISSUE.
- Three back-to-back requests with FIFO_DEPTH=2 while the first is in WAIT → third sees `req_ready=0` until a pop; all accepted requests get in-order responses.
- Hold `resp_ready=0` for 5 cycles → `resp_valid` and data stay stable, and the next request is not issued.
- Assert `reset` during WAIT with 2 queued requests → next cycle `mem_*=0`, `req_ready=1`, and no responses appear afterward.
